// File: rtl/ltc217x_pkg.sv
// ----------------------------------------------------------------------------
// ltc217x_pkg : shared types and constants for the LTC217x TX emulator  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ltc217x_pkg;

  localparam int         WORD_W    = 16;
  localparam int         SLOTS     = 8;
  localparam logic [7:0] FRAME_PAT = 8'hF0;

  typedef enum logic [1:0] {
    MODE_DATA = 2'b00,
    MODE_FIX  = 2'b01,
    MODE_RAMP = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Element 0 is channel 0; channels above 3 reuse index k mod 4.
  localparam logic [3:0][13:0] FIX_PAT = {14'h0000, 14'h1555, 14'h2AAA, 14'h3FFF};

endpackage

`default_nettype wire

// File: rtl/ltc217x_lane_ser.sv
// ----------------------------------------------------------------------------
// ltc217x_lane_ser : per-channel 16-bit to A/B lane pair serialiser    rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ltc217x_lane_ser
  import ltc217x_pkg::*;
(
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iLoad,
  input  logic              iShift,
  input  logic [WORD_W-1:0] iWord,
  output logic              oA,
  output logic              oB
);

  logic [WORD_W-1:0] sh;

  // The top bit pair goes straight to the outputs on load so slot 0 appears on the next cycle.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      sh <= '0;
      oA <= 1'b0;
      oB <= 1'b0;
    end else if (iLoad) begin
      oA <= iWord[WORD_W-1];
      oB <= iWord[WORD_W-2];
      sh <= {iWord[WORD_W-3:0], 2'b00};
    end else if (iShift) begin
      oA <= sh[WORD_W-1];
      oB <= sh[WORD_W-2];
      sh <= {sh[WORD_W-3:0], 2'b00};
    end else begin
      sh <= '0;
      oA <= 1'b0;
      oB <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ltc217x_tx_emu.sv
// ----------------------------------------------------------------------------
// ltc217x_tx_emu : LTC217x 2-lane serial LVDS output emulator           rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ltc217x_tx_emu
  import ltc217x_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DW     = 14,
  parameter int UCNT_W = 16
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iEn,
  input  logic [1:0]              iMode,
  input  logic [NCH-1:0][DW-1:0]  iData,
  input  logic                    iValid,
  output logic                    oReady,
  output logic [2*NCH-1:0]        oLane,
  output logic                    oFrame,
  output logic                    oFrmStart,
  output logic                    oBusy,
  output logic [UCNT_W-1:0]       oUnderrunCnt
);

  state_e                 state;
  logic [2:0]             slot;
  logic [NCH-1:0][DW-1:0] hold;
  logic                   hold_v;
  logic [NCH-1:0][DW-1:0] last;
  logic [DW-1:0]          ramp;
  logic [UCNT_W-1:0]      underrun_cnt;

  logic                   load;
  logic                   shift;
  logic                   accept;
  logic                   last_slot;
  logic                   is_data;
  logic                   is_ramp;
  logic                   have_sample;
  logic [NCH-1:0][DW-1:0] sel_smp;

  assign oReady       = ~hold_v;
  assign accept       = iValid & ~hold_v;
  assign last_slot    = (slot == 3'(SLOTS - 1));
  assign is_data      = (iMode == MODE_DATA);
  assign is_ramp      = (iMode == MODE_RAMP);
  assign have_sample  = hold_v | iValid;
  assign oUnderrunCnt = underrun_cnt;

  // Neither load nor shift means IDLE or the end of a drained frame: lanes go quiet.
  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    unique case (state)
      IDLE:       load = iEn;
      RUN, DRAIN: begin
        load  = last_slot & iEn;
        shift = ~last_slot;
      end
      default: ;
    endcase
  end

  // A same-cycle accept with an empty hold register bypasses straight into the frame.
  always_comb begin
    sel_smp = '0;
    for (int k = 0; k < NCH; k++) begin
      if (is_data)
        sel_smp[k] = hold_v ? hold[k] : (iValid ? iData[k] : last[k]);
      else if (is_ramp)
        sel_smp[k] = ramp + DW'(k);
      else
        sel_smp[k] = DW'(FIX_PAT[k[1:0]]);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state        <= IDLE;
      slot         <= 3'd0;
      oBusy        <= 1'b0;
      oFrame       <= 1'b0;
      oFrmStart    <= 1'b0;
      hold_v       <= 1'b0;
      hold         <= '0;
      last         <= '0;
      ramp         <= '0;
      underrun_cnt <= '0;
    end else begin
      oFrmStart <= load;
      if (load) begin
        state  <= RUN;
        slot   <= 3'd0;
        oBusy  <= 1'b1;
        oFrame <= FRAME_PAT[7];
      end else if (shift) begin
        slot   <= slot + 3'd1;
        oFrame <= FRAME_PAT[3'd6 - slot];
        if (state == RUN && !iEn)
          state <= DRAIN;
      end else begin
        state  <= IDLE;
        slot   <= 3'd0;
        oBusy  <= 1'b0;
        oFrame <= 1'b0;
      end

      if (load)
        hold_v <= 1'b0;
      else if (accept) begin
        hold_v <= 1'b1;
        hold   <= iData;
      end

      if (load && is_data) begin
        last <= sel_smp;
        if (!have_sample && !(&underrun_cnt))
          underrun_cnt <= underrun_cnt + UCNT_W'(1);
      end

      if (load && is_ramp)
        ramp <= ramp + DW'(1);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    ltc217x_lane_ser u_ser (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iLoad  (load),
      .iShift (shift),
      .iWord  ({sel_smp[k], {(WORD_W - DW){1'b0}}}),
      .oA     (oLane[2*k]),
      .oB     (oLane[2*k+1])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_ltc217x_tx_emu.sv
// ----------------------------------------------------------------------------
// tb_ltc217x_tx_emu : self-checking bench for ltc217x_tx_emu            rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ltc217x_tx_emu;

  localparam int NCH    = 4;
  localparam int DW     = 14;
  localparam int UCNT_W = 16;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en    = 1'b0;
  logic                   valid = 1'b0;
  logic [1:0]             mode  = 2'b00;
  logic [NCH-1:0][DW-1:0] data  = '0;
  logic                   ready;
  logic [2*NCH-1:0]       lane;
  logic                   frame;
  logic                   frm_start;
  logic                   busy;
  logic [UCNT_W-1:0]      ucnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] cap [NCH];
  logic [7:0]  cap_frame, cap_start, cap_l0, cap_l1;
  logic        cap_ready;

  always #5 clk = ~clk;

  ltc217x_tx_emu #(.NCH(NCH), .DW(DW), .UCNT_W(UCNT_W)) dut (
    .iClk         (clk),
    .iRstN        (rst_n),
    .iEn          (en),
    .iMode        (mode),
    .iData        (data),
    .iValid       (valid),
    .oReady       (ready),
    .oLane        (lane),
    .oFrame       (frame),
    .oFrmStart    (frm_start),
    .oBusy        (busy),
    .oUnderrunCnt (ucnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Receiver view of one lane: bits taken MSB-first, one per slot.
  function automatic logic [7:0] lane_bits(input logic [15:0] w, input int odd);
    logic [7:0] r;
    for (int s = 0; s < 8; s++) r[7-s] = w[15-2*s-odd];
    return r;
  endfunction

  function automatic logic [15:0] wd(input int smp);
    logic [13:0] s14;
    s14 = 14'(smp);
    return {s14, 2'b00};
  endfunction

  // give: 0 leave valid alone, 1 offer smp once at slot 1, 2 keep valid high with smp
  task automatic rx_frame(input int give, input logic [NCH-1:0][DW-1:0] smp);
    int n;
    n = 0;
    while (!frm_start && n < 64) begin
      tick();
      n++;
    end
    chk("frame_start_seen", {31'd0, frm_start}, 32'd1);
    cap_ready = ready;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < NCH; k++) begin
        cap[k][15-2*s] = lane[2*k];
        cap[k][14-2*s] = lane[2*k+1];
      end
      cap_frame[7-s] = frame;
      cap_start[7-s] = frm_start;
      cap_l0[7-s]    = lane[0];
      cap_l1[7-s]    = lane[1];
      if (give == 2) begin
        valid = 1'b1;
        data  = smp;
      end else if (give == 1 && s == 1) begin
        valid = 1'b1;
        data  = smp;
      end else if (give == 1 && s == 2) begin
        valid = 1'b0;
      end
      if (s < 7) tick();
    end
  endtask

  function automatic logic [NCH-1:0][DW-1:0] rnd_smp();
    logic [NCH-1:0][DW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = DW'($urandom);
    return r;
  endfunction

  initial begin
    logic [NCH-1:0][DW-1:0] smp, smp_a, smp_b;
    logic [NCH-1:0][DW-1:0] cur;
    logic [13:0] fix_m [4];
    int ramp_m, cnt_m, give;

    fix_m[0] = 14'h3FFF; fix_m[1] = 14'h2AAA; fix_m[2] = 14'h1555; fix_m[3] = 14'h0000;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_lane", 32'(lane), 32'd0);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_start", {31'd0, frm_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ucnt", 32'(ucnt), 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);

    // Data mode, ch0 = 2ABC preloaded into the hold register
    rst_n = 1'b1;
    smp = rnd_smp();
    smp[0] = 14'h2ABC;
    valid = 1'b1;
    data  = smp;
    tick();
    valid = 1'b0;
    chk("hold_full_ready", {31'd0, ready}, 32'd0);
    en = 1'b1;
    tick();
    rx_frame(0, smp);
    for (int k = 0; k < NCH; k++) chk($sformatf("t1_word%0d", k), 32'(cap[k]), 32'(wd(int'(smp[k]))));
    chk("t1_lane0", 32'(cap_l0), 32'(lane_bits(wd(14'h2ABC), 0)));
    chk("t1_lane1", 32'(cap_l1), 32'(lane_bits(wd(14'h2ABC), 1)));
    chk("t1_frame", 32'(cap_frame), 32'hF0);
    chk("t1_start", 32'(cap_start), 32'h80);
    chk("t1_ucnt", 32'(ucnt), 32'd0);

    // Fixed pattern; mode switched just before the load, valid held high
    mode = 2'b01;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) mode = 2'b11;
      rx_frame(2, rnd_smp());
      for (int k = 0; k < NCH; k++)
        chk($sformatf("t2_f%0d_ch%0d", f, k), 32'(cap[k]), 32'(wd(int'(fix_m[k % 4]))));
      chk("t2_ready", {31'd0, cap_ready}, 32'd1);
      chk("t2_ucnt", 32'(ucnt), 32'd0);
    end
    valid = 1'b0;

    // Ramp from reset, then a forced wrap
    rst_n = 1'b0; en = 1'b0;
    tick();
    rst_n = 1'b1; mode = 2'b10; en = 1'b1;
    tick();
    ramp_m = 0;
    for (int f = 0; f < 7; f++) begin
      if (f == 5) begin
        force dut.ramp = 14'h3FFF;
        #2;
        release dut.ramp;
        ramp_m = 16'h3FFF;
      end
      rx_frame(0, smp);
      for (int k = 0; k < NCH; k++)
        chk($sformatf("t3_f%0d_ch%0d", f, k), 32'(cap[k]), 32'(wd((ramp_m + k) % 16384)));
      ramp_m = (ramp_m + 1) % 16384;
    end
    chk("t3_ucnt", 32'(ucnt), 32'd0);

    // Data mode: bypass sample, then underruns retransmit it
    mode = 2'b00;
    smp = rnd_smp();
    smp[0] = 14'h1234;
    valid = 1'b1;
    data  = smp;
    tick();
    valid = 1'b0;
    rx_frame(0, smp);
    chk("t4_bypass_word", 32'(cap[0]), 32'(wd(16'h1234)));
    chk("t4_bypass_ucnt", 32'(ucnt), 32'd0);
    for (int f = 0; f < 3; f++) begin
      rx_frame(0, smp);
      for (int k = 0; k < NCH; k++)
        chk($sformatf("t4_f%0d_ch%0d", f, k), 32'(cap[k]), 32'(wd(int'(smp[k]))));
      chk($sformatf("t4_ucnt%0d", f), 32'(ucnt), 32'(f + 1));
    end
    force dut.underrun_cnt = 16'hFFFF;
    #2;
    release dut.underrun_cnt;
    rx_frame(0, smp);
    chk("t4_sat", 32'(ucnt), 32'h0000FFFF);
    chk("t4_sat_word", 32'(cap[0]), 32'(wd(16'h1234)));

    // Randomized data stream with random gaps
    rst_n = 1'b0; en = 1'b0;
    tick();
    rst_n = 1'b1; en = 1'b1;
    tick();
    cur   = '0;
    cnt_m = 1;
    for (int f = 0; f < 12; f++) begin
      give = int'($urandom_range(0, 1));
      smp  = rnd_smp();
      rx_frame(give, smp);
      for (int k = 0; k < NCH; k++)
        chk($sformatf("rnd_f%0d_ch%0d", f, k), 32'(cap[k]), 32'(wd(int'(cur[k]))));
      chk($sformatf("rnd_ucnt%0d", f), 32'(ucnt), 32'(cnt_m));
      if (give == 1) cur = smp;
      else if (cnt_m < 65535) cnt_m++;
    end

    // Enable dropped at slot 2: frame completes, then idle
    tick();
    chk("t5_start", {31'd0, frm_start}, 32'd1);
    tick(); tick();
    en = 1'b0;
    repeat (5) tick();
    chk("t5_busy_s7", {31'd0, busy}, 32'd1);
    tick();
    chk("t5_lane_idle", 32'(lane), 32'd0);
    chk("t5_frame_idle", {31'd0, frame}, 32'd0);
    chk("t5_busy_idle", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("t5_still_idle", {30'd0, busy, frm_start}, 32'd0);
    en = 1'b1;
    tick();
    chk("t5_restart", {31'd0, frm_start}, 32'd1);
    tick(); tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    tick();
    chk("t5_nogap_start", {31'd0, frm_start}, 32'd1);
    chk("t5_nogap_busy", {31'd0, busy}, 32'd1);

    // Mid-frame reset with a stale sample held
    smp_a = rnd_smp();
    valid = 1'b1;
    data  = smp_a;
    tick();
    valid = 1'b0;
    chk("t6_held", {31'd0, ready}, 32'd0);
    repeat (4) tick();
    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    chk("t6_lane", 32'(lane), 32'd0);
    chk("t6_flags", {29'd0, frame, frm_start, busy}, 32'd0);
    chk("t6_ucnt", 32'(ucnt), 32'd0);
    chk("t6_ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b1;
    smp_b = rnd_smp();
    smp_b[0] = ~smp_a[0];
    valid = 1'b1;
    data  = smp_b;
    tick();
    valid = 1'b0;
    en = 1'b1;
    tick();
    rx_frame(0, smp_b);
    for (int k = 0; k < NCH; k++)
      chk($sformatf("t6_word%0d", k), 32'(cap[k]), 32'(wd(int'(smp_b[k]))));
    chk("t6_ucnt_after", 32'(ucnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
